// File: rtl/bus_memory_responder.sv
// bus_memory_responder: word-addressed main-memory model on the target side of
// the LEG bus request/ready handshake. Every request is a single 32-bit beat.
// The responder answers it LATENCY cycles after capture with a one-cycle
// BusReady pulse.
// Optional feature: define BUS_RESP_OOR_EN to flag out-of-range beats with
// HError. Out-of-range writes are dropped and out-of-range reads return
// 32'hDEADBEEF. Without it, upper address bits alias modulo DEPTH.
module bus_memory_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HRequest,
  input  logic        HWrite,
  input  logic [31:0] HAddr,
  input  logic [31:0] HWData,
  output logic [31:0] HRData,
  output logic        BusReady,
  output logic        HError
);

  localparam int ADDRBITS = $clog2(DEPTH);
  localparam int CNTW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = (LATENCY >= 2) ? CNTW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDRBITS-1:0]   idx_q, idx_d;
  logic                  oor_q, oor_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0]           mem [DEPTH];

  logic                  in_oor;
  logic                  unused_addr_bits;

`ifdef BUS_RESP_OOR_EN
  assign in_oor           = |HAddr[31:ADDRBITS+2];
  assign unused_addr_bits = ^HAddr[1:0];
  assign HError           = (state_q == RESP) && oor_q;
`else
  assign in_oor           = 1'b0;
  assign unused_addr_bits = ^{HAddr[1:0], HAddr[31:ADDRBITS+2]};
  assign HError           = 1'b0;
`endif

  // Beat entering RESP: straight from the inputs when LATENCY=1, else from the capture registers.
  logic                rd_write;
  logic                rd_oor;
  logic [ADDRBITS-1:0] rd_idx;
  assign rd_write = (state_q == IDLE) ? HWrite : write_q;
  assign rd_oor   = (state_q == IDLE) ? in_oor : oor_q;
  assign rd_idx   = (state_q == IDLE) ? HAddr[ADDRBITS+1:2] : idx_q;

  assign BusReady = (state_q == RESP);
  assign HRData   = rdata_q;

  // Next-state logic: capture in IDLE, count down wait states, pulse ready in RESP.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case leaves one unassigned (no latches).
    logic enter_resp;
    enter_resp = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (HRequest) begin
          write_d = HWrite;
          idx_d   = HAddr[ADDRBITS+1:2];
          oor_d   = in_oor;
          wdata_d = HWData;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp && !rd_write) begin
      rdata_d = rd_oor ? 32'hDEADBEEF : mem[rd_idx];
    end
  end

  // Control and capture registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit a captured in-range write on the edge leaving RESP.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset. Reset reaches it only through state_q, which aborts any pending commit.
    if (state_q == RESP && write_q && !oor_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
// tb_bus_memory_responder: self-checking bench for bus_memory_responder.
// Two instances share the address/data/write inputs: A uses DEPTH=1024 and
// LATENCY=4, B uses DEPTH=64 and LATENCY=1. A word-array reference model
// predicts read data, HError and latency.
module tb_bus_memory_responder;

  localparam int DEPTH_A = 1024;
  localparam int LAT_A   = 4;
  localparam int DEPTH_B = 64;
  localparam int LAT_B   = 1;
`ifdef BUS_RESP_OOR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd_a, rd_b;
  logic        rdy_a, rdy_b, err_a, err_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] ref_a [DEPTH_A];
  bit          kn_a  [DEPTH_A];
  logic [31:0] ref_b [DEPTH_B];
  bit          kn_b  [DEPTH_B];

  bus_memory_responder #(.DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .HRequest(req_a), .HWrite(we), .HAddr(addr),
    .HWData(wdata), .HRData(rd_a), .BusReady(rdy_a), .HError(err_a)
  );

  bus_memory_responder #(.DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .HRequest(req_b), .HWrite(we), .HAddr(addr),
    .HWData(wdata), .HRData(rd_b), .BusReady(rdy_b), .HError(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int idx_of(input bit sel, input logic [31:0] a);
    return sel ? int'((a >> 2) % DEPTH_B) : int'((a >> 2) % DEPTH_A);
  endfunction

  function automatic bit oor_of(input bit sel, input logic [31:0] a);
    return OOR_EN && (sel ? ((a >> 8) != 0) : ((a >> 12) != 0));
  endfunction

  // Predicts one beat and updates the model memory. rd_chk=0 when the read data is unknowable.
  task automatic model(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] exp_rd, output bit exp_err, output bit rd_chk);
    int i;
    bit o;
    i = idx_of(sel, a);
    o = oor_of(sel, a);
    exp_err = o;
    exp_rd  = '0;
    rd_chk  = 1'b0;
    if (w) begin
      if (!o) begin
        if (sel) begin ref_b[i] = d; kn_b[i] = 1'b1; end
        else     begin ref_a[i] = d; kn_a[i] = 1'b1; end
      end
    end else if (o) begin
      exp_rd = 32'hDEADBEEF;
      rd_chk = 1'b1;
    end else begin
      exp_rd = sel ? ref_b[i] : ref_a[i];
      rd_chk = sel ? kn_b[i] : kn_a[i];
    end
  endtask

  // ---------------- bus driver ----------------
  // Drives a beat at the start of a cycle and leaves HRequest high. Returns at the sample point of the ready cycle.
  task automatic beat(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit err, output int lat, output int rcyc);
    @(posedge clk);
    #1;
    we = w; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    lat = -1; rd = '0; err = 1'b0; rcyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sel ? rdy_b : rdy_a) begin
        lat  = c;
        rd   = sel ? rd_b : rd_a;
        err  = sel ? err_b : err_a;
        rcyc = cyc;
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    req_a = 1'b1; req_b = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rdy_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0 || rdy_b !== 1'b0 || rd_b !== 32'h0 || err_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got rdyA=%b rdA=%h errA=%b rdyB=%b rdB=%h errB=%b, want 0/00000000/0 on both",
                 rdy_a, rd_a, err_a, rdy_b, rd_b, err_b);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] rd, erd; bit err, eerr, chk; int lat, rc;
    model(0, 1, 32'h10, 32'hCAFEF00D, erd, eerr, chk);
    beat(0, 1, 32'h10, 32'hCAFEF00D, rd, err, lat, rc);
    idle();
    checks++;
    if (lat != LAT_A || err !== 1'b0) begin
      errors++; $display("FAIL single_write: latency=%0d err=%b, want %0d/0", lat, err, LAT_A);
    end
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++; $display("FAIL single_write_pulse: BusReady=%b one cycle after ready, want 0", rdy_a);
    end
    model(0, 0, 32'h10, 32'h0, erd, eerr, chk);
    beat(0, 0, 32'h10, 32'h0, rd, err, lat, rc);
    idle();
    checks++;
    if (lat != LAT_A || rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL single_read: latency=%0d data=%h, want %0d/cafef00d", lat, rd, LAT_A);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, erd; bit err, eerr, chk; int lat, rc;
    model(0, 1, 32'h10, 32'h1234_5678, erd, eerr, chk);
    beat(0, 1, 32'h10, 32'h1234_5678, rd, err, lat, rc);
    idle();
    @(posedge clk);
    #1;
    we = 1'b1; addr = 32'h10; wdata = 32'h0BAD_0BAD; req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (rdy_a !== 1'b0) begin
        errors++; $display("FAIL abort_no_ready: BusReady=%b during reset, want 0", rdy_a);
      end
    end
    req_a = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    model(0, 0, 32'h10, 32'h0, erd, eerr, chk);
    beat(0, 0, 32'h10, 32'h0, rd, err, lat, rc);
    idle();
    checks++;
    if (lat != LAT_A || rd !== 32'h1234_5678) begin
      errors++; $display("FAIL abort_old_data: latency=%0d data=%h, want %0d/12345678", lat, rd, LAT_A);
    end
  endtask

  task automatic test_line_fill();
    logic [31:0] rd, erd; bit err, eerr, chk; int lat, rc, prev;
    for (int i = 0; i < 4; i++) begin
      model(0, 1, 32'h20 + 32'(4 * i), 32'(i + 1), erd, eerr, chk);
      beat(0, 1, 32'h20 + 32'(4 * i), 32'(i + 1), rd, err, lat, rc);
      idle();
    end
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      beat(0, 0, 32'h20 + 32'(4 * i), 32'h0, rd, err, lat, rc);
      checks++;
      if (lat != LAT_A || rd !== 32'(i + 1) || (i > 0 && rc - prev != LAT_A + 1)) begin
        errors++;
        $display("FAIL line_fill[%0d]: latency=%0d data=%h gap=%0d, want %0d/%h/%0d",
                 i, lat, rd, rc - prev, LAT_A, 32'(i + 1), LAT_A + 1);
      end
      prev = rc;
    end
    idle();
  endtask

  task automatic test_latency1_b2b();
    logic [31:0] rd, erd; bit err, eerr, chk; int lat1, lat2, rc1, rc2;
    model(1, 1, 32'h40, 32'h55AA55AA, erd, eerr, chk);
    beat(1, 1, 32'h40, 32'h55AA55AA, rd, err, lat1, rc1);
    model(1, 0, 32'h40, 32'h0, erd, eerr, chk);
    beat(1, 0, 32'h40, 32'h0, rd, err, lat2, rc2);
    idle();
    checks++;
    if (lat1 != LAT_B || lat2 != LAT_B || rc2 - rc1 != 2) begin
      errors++; $display("FAIL lat1_timing: latencies=%0d,%0d gap=%0d, want 1,1 gap 2", lat1, lat2, rc2 - rc1);
    end
    checks++;
    if (rd !== 32'h55AA55AA) begin
      errors++; $display("FAIL lat1_data: data=%h, want 55aa55aa", rd);
    end
  endtask

  task automatic test_mid_beat_change();
    logic [31:0] rd, erd; bit err, eerr, chk; int lat, rc;
    model(0, 1, 32'h84, 32'h0000_A5A5, erd, eerr, chk);
    beat(0, 1, 32'h84, 32'h0000_A5A5, rd, err, lat, rc);
    idle();
    model(0, 1, 32'h80, 32'h1, erd, eerr, chk);
    @(posedge clk);
    #1;
    we = 1'b1; addr = 32'h80; wdata = 32'h1; req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0; addr = 32'h84; wdata = 32'hFFFF_0000; we = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rdy_a) begin lat = c; break; end
    end
    checks++;
    if (lat != LAT_A) begin
      errors++; $display("FAIL mid_change_ready: latency=%0d, want %0d", lat, LAT_A);
    end
    beat(0, 0, 32'h80, 32'h0, rd, err, lat, rc);
    idle();
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL mid_change_0x80: data=%h, want 00000001", rd);
    end
    beat(0, 0, 32'h84, 32'h0, rd, err, lat, rc);
    idle();
    checks++;
    if (rd !== 32'h0000_A5A5) begin
      errors++; $display("FAIL mid_change_0x84: data=%h, want 0000a5a5", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, erd; bit err, eerr, chk; int lat, rc;
    model(0, 1, 32'h0, 32'h11, erd, eerr, chk);
    beat(0, 1, 32'h0, 32'h11, rd, err, lat, rc);
    idle();
    model(0, 1, 32'h1000, 32'h77, erd, eerr, chk);
    beat(0, 1, 32'h1000, 32'h77, rd, err, lat, rc);
    idle();
    checks++;
    if (lat != LAT_A || err !== OOR_EN) begin
      errors++; $display("FAIL oor_write: latency=%0d HError=%b, want %0d/%b", lat, err, LAT_A, OOR_EN);
    end
    beat(0, 0, 32'h0, 32'h0, rd, err, lat, rc);
    idle();
    checks++;
    if (rd !== (OOR_EN ? 32'h11 : 32'h77) || err !== 1'b0) begin
      errors++; $display("FAIL oor_word0: data=%h HError=%b, want %h/0", rd, err, OOR_EN ? 32'h11 : 32'h77);
    end
    beat(0, 0, 32'h1000, 32'h0, rd, err, lat, rc);
    idle();
    checks++;
    if (rd !== (OOR_EN ? 32'hDEADBEEF : 32'h77) || err !== OOR_EN) begin
      errors++; $display("FAIL oor_read: data=%h HError=%b, want %h/%b", rd, err, OOR_EN ? 32'hDEADBEEF : 32'h77, OOR_EN);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; bit err, eerr, chk, sel, w, last_sel; int lat, rc;
    last_sel = 1'b0;
    for (int n = 0; n < 48; n++) begin
      sel = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      a   = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = a | (32'($urandom_range(1, 255)) << (sel ? 8 : 12));
      if (sel != last_sel) idle();
      model(sel, w, a, d, erd, eerr, chk);
      beat(sel, w, a, d, rd, err, lat, rc);
      checks++;
      if (lat != (sel ? LAT_B : LAT_A) || err !== eerr || (!w && chk && rd !== erd)) begin
        errors++;
        $display("FAIL random[%0d] dut=%0d we=%b addr=%h: latency=%0d err=%b data=%h, want %0d/%b/%h",
                 n, sel, w, a, lat, err, rd, sel ? LAT_B : LAT_A, eerr, erd);
      end
      if ($urandom_range(0, 1) == 1) idle();
      last_sel = sel;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_abort();
    test_line_fill();
    test_latency1_b2b();
    test_mid_beat_change();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
